// File: rtl/sequenciador_pkg.sv
// Shared definitions for the register-bank sequencer: opcodes, FSM states
// and the bit positions of the fixed 8-bit instruction word.
package sequenciador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_LI  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    ESCRITA = 2'd2
  } estado_e;

  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;

endpackage

// File: rtl/ula_8bits.sv
// Combinational ALU for the sequencer: ADD/SUB/MOV/LI with zero and
// carry/borrow flags. Carry on SUB is the borrow, i.e. a < b unsigned.
module ula_8bits
  import sequenciador_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] res;
  logic              cy;

  // The extra top bit of the widened subtraction is exactly the borrow.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    res  = '0;
    cy   = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        res = sum[DATA_W-1:0];
        cy  = sum[DATA_W];
      end
      OP_SUB: begin
        res = diff[DATA_W-1:0];
        cy  = diff[DATA_W];
      end
      OP_MOV:  res = b_i;
      OP_LI:   res = imm_i;
      default: res = '0;
    endcase
  end

  assign result_o = res;
  assign carry_o  = cy;
  assign zero_o   = (res == '0);

endmodule

// File: rtl/sequenciador_registradores.sv
// Three-state access sequencer for BancoDeRegistradores: accepts one
// instruction, reads rd/rs, then writes the ALU result back for one cycle.
module sequenciador_registradores
  import sequenciador_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        Instr,
  input  logic [DATA_W-1:0] Imediato,
  input  logic              InstrValid,
  output logic              InstrReady,
  output logic [2:0]        RegLido1,
  output logic [2:0]        RegLido2,
  input  logic [DATA_W-1:0] Dado1,
  input  logic [DATA_W-1:0] Dado2,
  output logic [2:0]        RegEscr,
  output logic [DATA_W-1:0] DadoEscr,
  output logic              RegWrite,
  output logic              Done,
  output logic              Zero,
  output logic              Carry
);

  estado_e           estado_q;
  opcode_e           opcode_q;
  logic [DATA_W-1:0] imm_q;
  logic [2:0]        regLido1_q;
  logic [2:0]        regLido2_q;
  logic [2:0]        regEscr_q;
  logic [DATA_W-1:0] dadoEscr_q;
  logic              regWrite_q;
  logic              done_q;
  logic              zero_q;
  logic              carry_q;

  logic [DATA_W-1:0] ulaResult;
  logic              ulaZero;
  logic              ulaCarry;

  ula_8bits #(.DATA_W(DATA_W)) u_ula (
    .opcode_i (opcode_q),
    .a_i      (Dado1),
    .b_i      (Dado2),
    .imm_i    (imm_q),
    .result_o (ulaResult),
    .zero_o   (ulaZero),
    .carry_o  (ulaCarry)
  );

  // RegLido1 doubles as the latched rd, so it also feeds the write address.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q   <= OCIOSO;
      opcode_q   <= OP_ADD;
      imm_q      <= '0;
      regLido1_q <= '0;
      regLido2_q <= '0;
      regEscr_q  <= '0;
      dadoEscr_q <= '0;
      regWrite_q <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (InstrValid) begin
            opcode_q   <= opcode_e'(Instr[OPC_MSB:OPC_LSB]);
            regLido1_q <= Instr[RD_MSB:RD_LSB];
            regLido2_q <= Instr[RS_MSB:RS_LSB];
            imm_q      <= Imediato;
            estado_q   <= LEITURA;
          end
        end
        LEITURA: begin
          dadoEscr_q <= ulaResult;
          regEscr_q  <= regLido1_q;
          regWrite_q <= 1'b1;
          done_q     <= 1'b1;
          if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
            zero_q  <= ulaZero;
            carry_q <= ulaCarry;
          end
          estado_q <= ESCRITA;
        end
        ESCRITA: begin
          regWrite_q <= 1'b0;
          done_q     <= 1'b0;
          estado_q   <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign InstrReady = Reset && (estado_q == OCIOSO);
  assign RegLido1   = regLido1_q;
  assign RegLido2   = regLido2_q;
  assign RegEscr    = regEscr_q;
  assign DadoEscr   = dadoEscr_q;
  assign RegWrite   = regWrite_q;
  assign Done       = done_q;
  assign Zero       = zero_q;
  assign Carry      = carry_q;

endmodule

// File: doc/sequenciador_registradores.md
# sequenciador_registradores

- Multi-cycle initiator that drives the 8-bit processor's register bank (`BancoDeRegistradores`).
- Accepts one 8-bit register-to-register instruction per valid/ready handshake.
- Issues the two read addresses, computes the result from the returned data, then writes it back through `RegWrite`.
- Sits between the instruction source and the bank: it is the access sequencer for the bank's read/write port set.

## Interface
Parameters:
- DATA_W, 8, datapath width; must equal the bank word width. Instruction format is fixed at 8 bits regardless.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  8  instruction: [7:6] opcode, [5:3] rd, [2:0] rs.
- Imediato  in  DATA_W  immediate operand, sampled with Instr.
- InstrValid  in  1  Instr/Imediato are valid.
- InstrReady  out  1  sequencer can accept an instruction.
- RegLido1  out  3  bank read address 1 (rd).
- RegLido2  out  3  bank read address 2 (rs).
- Dado1  in  DATA_W  bank read data 1.
- Dado2  in  DATA_W  bank read data 2.
- RegEscr  out  3  bank write address.
- DadoEscr  out  DATA_W  bank write data.
- RegWrite  out  1  bank write enable.
- Done  out  1  instruction completes this cycle.
- Zero  out  1  flag: last ADD/SUB result == 0.
- Carry  out  1  flag: ADD carry-out, or SUB borrow.

## Operation
- Opcodes:
  - 00 ADD: rd = rd + rs.
  - 01 SUB: rd = rd - rs.
  - 10 MOV: rd = rs.
  - 11 LI: rd = Imediato; rs is ignored.
- FSM states: OCIOSO, LEITURA, ESCRITA.
- OCIOSO:
  - InstrReady = 1 (combinational from state).
  - On InstrValid at posedge: latch opcode, rd, rs and Imediato; drive RegLido1 = rd and RegLido2 = rs; go to LEITURA.
  - InstrValid low: stay.
- LEITURA:
  - InstrReady = 0.
  - Addresses held stable; the bank updates Dado1/Dado2 on the mid-cycle negedge.
  - At the next posedge: compute the result from Dado1/Dado2 (or the latched Imediato); register DadoEscr = result and RegEscr = rd; set RegWrite = 1 and Done = 1; go to ESCRITA.
- ESCRITA:
  - RegWrite and Done are high for exactly this cycle; the bank commits at the closing posedge.
  - At that posedge: RegWrite = 0, Done = 0; go to OCIOSO.
- Arithmetic:
  - Modulo 2^DATA_W.
  - ADD: Carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: Carry = 1 iff rd < rs (unsigned).
  - Zero = (result == 0).
- Flags update on the LEITURA→ESCRITA edge, for ADD/SUB only. MOV and LI leave Zero/Carry unchanged.
- All opcodes take the same path, including LI, which does not consume the read data. Latency is uniform.
- rd == rs is legal. SUB rd,rd yields 0 with Zero = 1 and Carry = 0.

## Timing
- Reset values (asserted asynchronously, immediately):
  - state = OCIOSO.
  - RegLido1 = RegLido2 = RegEscr = 0.
  - DadoEscr = 0.
  - RegWrite = 0, Done = 0, Zero = 0, Carry = 0.
  - InstrReady = 0 while Reset is low.
- Handshake accepted at posedge k → LEITURA during k..k+1 → ESCRITA during k+1..k+2 → bank write at posedge k+2.
- Earliest next accept is posedge k+3. Throughput is 1 instruction per 3 cycles.
- No RAW hazard: a write at posedge k+2 is visible to the following instruction's LEITURA negedge.
- InstrValid or Instr changes outside OCIOSO are ignored.
- Reset mid-instruction: RegWrite drops immediately and no write occurs. The aborted instruction is lost; flags clear.

## Structure
- Package `sequenciador_pkg`:
  - Opcode constants OP_ADD, OP_SUB, OP_MOV, OP_LI.
  - State encoding OCIOSO/LEITURA/ESCRITA.
  - Instruction field positions.
- Sub-module `ula_8bits`: combinational; inputs opcode, a, b, imm; outputs result, zero, carry.
- The top holds the FSM and the output registers.

## Test plan
Bench instantiates the sequencer with the existing bank model.
- Reset low mid-ESCRITA of LI r1,0x55 → RegWrite falls immediately; a later MOV r2,r1 reads the pre-reset content, not 0x55; all outputs return to reset values.
- LI r0..r7 with values 1..8, then MOV r0,rN for each N → DadoEscr = N+1 with Done each time; each instruction takes 3 cycles.
- LI r1,0xF0; LI r2,0x20; ADD r1,r2 → DadoEscr = 0x10, Carry = 1, Zero = 0.
- LI r3,0x05; LI r4,0x07; SUB r3,r4 → DadoEscr = 0xFE, Carry = 1. Then SUB r4,r4 → 0x00, Zero = 1, Carry = 0.
- Back-to-back: LI r5,0x3C immediately followed by ADD r5,r5 with InstrValid held high → result 0x78; InstrReady low in LEITURA/ESCRITA; second accept exactly 3 cycles after the first.
- MOV after SUB gave Zero = 1 → Zero stays 1. Toggling InstrValid during LEITURA → no extra instruction accepted.
